// File: rtl/calc_mem_arbiter_if.sv
// calc_mem_arbiter_if: requester-side bundle of the two-port calculator SRAM arbiter
interface calc_mem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int WORD_W = 64
);
  logic [1:0]          req, we, lock, gnt, rvalid;
  logic [2*ADDR_W-1:0] addr;
  logic [2*WORD_W-1:0] wdata;
  logic [WORD_W-1:0]   rdata;
  modport master (output req, we, lock, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, lock, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/calc_mem_arbiter.sv
// calc_mem_arbiter: round-robin, lockable arbiter sharing the calculator SRAM between controller and host
module calc_mem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int WORD_W   = 64,
  parameter int RD_LAT   = 1,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  calc_mem_arbiter_if.slave bus,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [WORD_W-1:0] mem_wdata_o,
  input  logic [WORD_W-1:0] mem_rdata_i,
  output logic              owner_o
);
  localparam int CW = $clog2(LOCK_MAX + 1);
  typedef enum logic [2:0] {IDLE, GRANT0, GRANT1, LOCKED0, LOCKED1} state_t;
  state_t            state, state_nx;
  logic              ptr, ptr_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [1:0]        brk, brk_nx;
  logic [1:0]        req, gnt;
  logic              hold, win, lk, trip;
  logic [RD_LAT-1:0] tv, tid;
  // state, round-robin pointer, starvation counter, broken-lock flags and read-tag pipeline
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      ptr   <= 1'b1;
      cnt   <= '0;
      brk   <= '0;
      tv    <= '0;
      tid   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      cnt   <= cnt_nx;
      brk   <= brk_nx;
      tv    <= RD_LAT'({tv, mem_en_o & ~mem_we_o});
      tid   <= RD_LAT'({tid, win});
    end
  end
  // next state: lock entry/hold, starvation counting and lock breaking
  always_comb begin
    lk       = mem_en_o & bus.lock[win] & ~brk[win];
    trip     = lk && req[~win] && cnt == CW'(LOCK_MAX - 1);
    cnt_nx   = (lk && req[~win] && !trip) ? cnt + 1'b1 : '0;
    state_nx = !mem_en_o ? IDLE : (lk && !trip) ? (win ? LOCKED1 : LOCKED0) : (win ? GRANT1 : GRANT0);
    ptr_nx   = mem_en_o ? win : ptr;
    brk_nx   = (brk & req & bus.lock) | (trip ? (win ? 2'b10 : 2'b01) : 2'b00);
  end
  // outputs: combinational grant, SRAM mux and read-return routing
  always_comb begin
    req         = bus.req & {2{rst_ni}};
    hold        = (state == LOCKED0 && req[0] && bus.lock[0]) || (state == LOCKED1 && req[1] && bus.lock[1]);
    win         = hold ? (state == LOCKED1) : (&req ? ~ptr : req[1] & ~req[0]);
    gnt         = |req ? (win ? 2'b10 : 2'b01) : 2'b00;
    bus.gnt     = gnt;
    owner_o     = gnt[1];
    mem_en_o    = |gnt;
    mem_we_o    = mem_en_o & bus.we[win];
    mem_addr_o  = !mem_en_o ? '0 : win ? bus.addr[ADDR_W +: ADDR_W] : bus.addr[0 +: ADDR_W];
    mem_wdata_o = !mem_en_o ? '0 : win ? bus.wdata[WORD_W +: WORD_W] : bus.wdata[0 +: WORD_W];
    bus.rvalid  = tv[RD_LAT-1] ? (tid[RD_LAT-1] ? 2'b10 : 2'b01) : 2'b00;
    bus.rdata   = tv[RD_LAT-1] ? mem_rdata_i : '0;
  end
endmodule
